// File: rtl/apb_reg_slave.sv
// APB completer with a bank of 32-bit registers, a read-only ID at index 0,
// byte-strobed writes, fixed wait-state insertion and PSLVERR on bad accesses.
module apb_reg_slave #(
    parameter int          NUM_REGS    = 16,
    parameter int          WAIT_CYCLES = 2,
    parameter logic [31:0] ID_VALUE    = 32'hA5B0_0001
) (
    input  logic        PCLK,
    input  logic        PRSTn,
    input  logic        PSEL,
    input  logic        PENABLE,
    input  logic        PWRITE,
    input  logic [31:0] PADDR,
    input  logic [31:0] PWDATA,
    input  logic [3:0]  PSTRB,
    output logic [31:0] PRDATA,
    output logic        PREADY,
    output logic        PSLVERR
);

    localparam int IDX_W = $clog2(NUM_REGS);

    typedef enum logic {IDLE, ACCESS} state_t;

    state_t      state, next_state;
    logic [3:0]  wait_cnt;
    logic [31:0] regs [NUM_REGS];
    logic [27:0] idx;
    logic [IDX_W-1:0] sel;
    logic        err;
    logic        commit;
    logic [1:0]  unused_addr;

    // Address bits 31:30 belong to the interconnect's slave select.
    assign unused_addr = PADDR[31:30];
    assign idx         = PADDR[29:2];
    assign sel         = idx[IDX_W-1:0];
    assign err         = (PADDR[1:0] != 2'b00) || (idx >= 28'(NUM_REGS)) || (PWRITE && idx == '0);

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge PCLK or negedge PRSTn) begin
        if (!PRSTn) state <= IDLE;
        else        state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:   if (PSEL) next_state = ACCESS;
            ACCESS: if (!PSEL || !PENABLE || wait_cnt == '0) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Counter holds at zero rather than wrapping.
    always_ff @(posedge PCLK or negedge PRSTn) begin
        if (!PRSTn)                                wait_cnt <= '0;
        else if (state == IDLE && PSEL)            wait_cnt <= 4'(WAIT_CYCLES);
        else if (state == ACCESS && wait_cnt != '0) wait_cnt <= wait_cnt - 4'd1;
    end

    // NOTE: every output gets a default first, so no path through the block can infer a latch.
    always_comb begin
        PREADY  = (state == ACCESS) && (wait_cnt == '0) && PSEL && PENABLE;
        PSLVERR = PREADY && err;
        commit  = PREADY && PWRITE && !err;
        PRDATA  = '0;
        if (PREADY && !PWRITE && !err)
            PRDATA = (idx == '0) ? ID_VALUE : regs[sel];
    end

    // NOTE: the register bank is flops, not RAM, so it can and must clear on reset.
    always_ff @(posedge PCLK or negedge PRSTn) begin
        if (!PRSTn) begin
            for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
        end else if (commit) begin
            for (int b = 0; b < 4; b++)
                if (PSTRB[b]) regs[sel][8*b +: 8] <= PWDATA[8*b +: 8];
        end
    end

endmodule

// File: tb/tb_apb_reg_slave.sv
// Scoreboard bench for apb_reg_slave: instance 0 has 2 wait states, instance 1 has none.
module tb_apb_reg_slave;

    localparam logic [31:0] ID = 32'hA5B0_0001;
    localparam int          NR = 16;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          setup;
        int          lat;
    } item_t;

    logic        PCLK = 1'b0;
    logic        PRSTn;
    logic        psel [2];
    logic        penable, pwrite;
    logic [31:0] paddr, pwdata;
    logic [3:0]  pstrb;
    logic [31:0] prdata [2];
    logic        pready [2];
    logic        pslverr [2];

    item_t       q [2][$];
    logic [31:0] model [2][NR];
    int          cyc = 0;
    int          n_vec = 0;
    int          n_err = 0;

    apb_reg_slave #(.NUM_REGS(NR), .WAIT_CYCLES(2), .ID_VALUE(ID)) dut_w2 (
        .PCLK(PCLK), .PRSTn(PRSTn), .PSEL(psel[0]), .PENABLE(penable), .PWRITE(pwrite),
        .PADDR(paddr), .PWDATA(pwdata), .PSTRB(pstrb),
        .PRDATA(prdata[0]), .PREADY(pready[0]), .PSLVERR(pslverr[0]));

    apb_reg_slave #(.NUM_REGS(NR), .WAIT_CYCLES(0), .ID_VALUE(ID)) dut_w0 (
        .PCLK(PCLK), .PRSTn(PRSTn), .PSEL(psel[1]), .PENABLE(penable), .PWRITE(pwrite),
        .PADDR(paddr), .PWDATA(pwdata), .PSTRB(pstrb),
        .PRDATA(prdata[1]), .PREADY(pready[1]), .PSLVERR(pslverr[1]));

    always #5 PCLK = ~PCLK;
    always @(posedge PCLK) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic clear_model();
        for (int d = 0; d < 2; d++)
            for (int i = 0; i < NR; i++) model[d][i] = '0;
    endtask

    // Reference: APB register-bank rules applied to an array of words.
    function automatic item_t predict(input int d, input logic w, input logic [31:0] a,
                                      input logic [31:0] wd, input logic [3:0] s);
        item_t it;
        int    i;
        logic  bad;
        i   = int'(a[29:2]);
        bad = (a % 4 != 0) || (i >= NR) || (w && i == 0);
        it.err   = bad;
        it.rdata = '0;
        if (w && !bad) begin
            for (int b = 0; b < 4; b++)
                if (s[b]) model[d][i][8*b +: 8] = wd[8*b +: 8];
        end else if (!w && !bad) begin
            it.rdata = (i == 0) ? ID : model[d][i];
        end
        it.lat   = (d == 0) ? 3 : 1;
        it.setup = 0;
        return it;
    endfunction

    // Called at cycle start (just after a rising edge); returns at the start of the cycle after completion.
    task automatic xfer(input int d, input logic w, input logic [31:0] a,
                        input logic [31:0] wd, input logic [3:0] s);
        item_t it;
        bit    done;
        it       = predict(d, w, a, wd, s);
        it.setup = cyc;
        q[d].push_back(it);
        psel[d] = 1'b1; penable = 1'b0; pwrite = w; paddr = a; pwdata = wd; pstrb = s;
        @(posedge PCLK); #1;
        penable = 1'b1;
        done = 1'b0;
        for (int k = 0; k < 40 && !done; k++) begin
            @(negedge PCLK);
            if (pready[d]) done = 1'b1;
            @(posedge PCLK); #1;
        end
        check("xfer_completed", {31'b0, done}, 32'd1);
        psel[d] = 1'b0; penable = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(posedge PCLK); #1; end
    endtask

    task automatic mon(input int d);
        item_t it;
        if (pready[d]) begin
            if (q[d].size() == 0) begin
                n_vec++; n_err++;
                $display("FAIL unexpected_pready dut%0d: got PREADY=1 expected no transfer (t=%0t)", d, $time);
            end else begin
                it = q[d].pop_front();
                check($sformatf("prdata_dut%0d", d), prdata[d], it.rdata);
                check($sformatf("pslverr_dut%0d", d), {31'b0, pslverr[d]}, {31'b0, it.err});
                check($sformatf("latency_dut%0d", d), 32'(cyc - it.setup), 32'(it.lat));
            end
        end else begin
            check($sformatf("idle_pslverr_dut%0d", d), {31'b0, pslverr[d]}, 32'd0);
            check($sformatf("idle_prdata_dut%0d", d), prdata[d], 32'd0);
        end
    endtask

    always @(negedge PCLK) mon(0);
    always @(negedge PCLK) mon(1);

    initial begin
        logic [31:0] a;
        int          d, i;
        PRSTn = 1'b0; psel[0] = 1'b0; psel[1] = 1'b0; penable = 1'b0;
        pwrite = 1'b0; paddr = '0; pwdata = '0; pstrb = '0;
        clear_model();
        #2;
        check("rst_pready", {31'b0, pready[0]}, 32'd0);
        check("rst_prdata", prdata[0], 32'd0);
        check("rst_pslverr", {31'b0, pslverr[0]}, 32'd0);
        idle(3);
        PRSTn = 1'b1;
        idle(1);

        // ID read, strobed writes, error cases
        xfer(0, 1'b0, 32'h0, 32'h0, 4'h0);
        xfer(0, 1'b1, 32'h4, 32'h1122_3344, 4'hF);
        xfer(0, 1'b1, 32'h4, 32'hFFFF_FFFF, 4'b0101);
        xfer(0, 1'b0, 32'h4, 32'h0, 4'h0);
        check("model_strobe_merge", model[0][1], 32'h11FF_33FF);
        xfer(0, 1'b1, 32'h0, 32'hDEAD_0000, 4'hF);
        xfer(0, 1'b0, 32'h0, 32'h0, 4'h0);
        xfer(0, 1'b0, 32'h40, 32'h0, 4'h0);
        xfer(0, 1'b0, 32'h6, 32'h0, 4'h0);
        xfer(0, 1'b1, 32'h8, 32'hCAFE_F00D, 4'h0);
        xfer(0, 1'b0, 32'h8, 32'h0, 4'h0);

        // Write to idx3 aborted by PENABLE dropping in the second access cycle
        psel[0] = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 32'hC; pwdata = 32'h5555_AAAA; pstrb = 4'hF;
        idle(1); penable = 1'b1;
        idle(1); penable = 1'b0;
        idle(1); psel[0] = 1'b0;
        idle(2);
        xfer(0, 1'b0, 32'hC, 32'h0, 4'h0);

        // Zero-wait instance, back-to-back write then read
        xfer(1, 1'b1, 32'h14, 32'hDEAD_BEEF, 4'hF);
        xfer(1, 1'b0, 32'h14, 32'h0, 4'h0);
        xfer(1, 1'b0, 32'h0, 32'h0, 4'h0);
        idle(1);

        // Randomised traffic on both instances
        repeat (120) begin
            d = int'($urandom_range(0, 1));
            i = int'($urandom_range(0, NR + 1));
            a = (32'($urandom_range(0, 3)) << 30) | (32'(i) << 2);
            if ($urandom_range(0, 7) == 0) a = a | 32'($urandom_range(1, 3));
            xfer(d, 1'($urandom), a, $urandom, 4'($urandom));
            idle(int'($urandom_range(0, 2)));
        end

        // Reset asserted during the wait of a write to idx2
        psel[0] = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 32'h8; pwdata = 32'h1234; pstrb = 4'hF;
        idle(1); penable = 1'b1;
        #2 PRSTn = 1'b0;
        #1;
        check("midrst_pready", {31'b0, pready[0]}, 32'd0);
        check("midrst_prdata", prdata[0], 32'd0);
        check("midrst_pslverr", {31'b0, pslverr[0]}, 32'd0);
        psel[0] = 1'b0; penable = 1'b0;
        clear_model();
        idle(2);
        PRSTn = 1'b1;
        idle(1);
        xfer(0, 1'b0, 32'h8, 32'h0, 4'h0);
        xfer(0, 1'b0, 32'h4, 32'h0, 4'h0);
        xfer(1, 1'b0, 32'h14, 32'h0, 4'h0);
        idle(3);

        check("queue0_drained", 32'(q[0].size()), 32'd0);
        check("queue1_drained", 32'(q[1].size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
